// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Exactly one access is in flight; reads return through a shared registered rdata.
module ram_arbiter #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [ADDR_SIZE-1:0] addr0,
    input  logic [WORD_SIZE-1:0] wdata0,
    output logic                 gnt0,
    output logic                 rvalid0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0] wdata1,
    output logic                 gnt1,
    output logic                 rvalid1,
    output logic [WORD_SIZE-1:0] rdata,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    output logic                 ram_wren,
    input  logic [WORD_SIZE-1:0] ram_q,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic                 owner_reg, owner_next;
    logic                 last_owner_reg, last_owner_next;
    logic                 we_reg, we_next;
    logic [ADDR_SIZE-1:0] addr_reg, addr_next;
    logic [WORD_SIZE-1:0] wdata_reg, wdata_next;
    logic [WORD_SIZE-1:0] rdata_reg, rdata_next;
    logic [1:0]           rvalid_reg, rvalid_next;

    logic [1:0]           req_vec;
    logic [1:0]           we_vec;
    logic [1:0]           gnt_vec;
    logic [ADDR_SIZE-1:0] addr_vec [2];
    logic [WORD_SIZE-1:0] wdata_vec [2];
    logic                 winner;

    assign req_vec      = {req1, req0};
    assign we_vec       = {we1, we0};
    assign addr_vec[0]  = addr0;
    assign addr_vec[1]  = addr1;
    assign wdata_vec[0] = wdata0;
    assign wdata_vec[1] = wdata1;

    // Grant is a decode of the ACCESS state; rvalid is registered off the RDWAIT exit.
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign gnt_vec[gi]     = (state_reg == ACCESS) && (owner_reg == 1'(gi));
        assign rvalid_next[gi] = (state_reg == RDWAIT) && (owner_reg == 1'(gi));
    end

    // On a tie the port that did not win last time gets the RAM.
    always_comb begin
        winner = req_vec[1];
        if (req_vec[0] && req_vec[1]) begin
            winner = ~last_owner_reg;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        rdata_next      = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    state_next      = ACCESS;
                    owner_next      = winner;
                    last_owner_next = winner;
                    we_next         = we_vec[winner];
                    addr_next       = addr_vec[winner];
                    wdata_next      = wdata_vec[winner];
                end
            end
            ACCESS: begin
                state_next = we_reg ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                state_next = IDLE;
                rdata_next = ram_q;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
            rvalid_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            rdata_reg      <= rdata_next;
            rvalid_reg     <= rvalid_next;
        end
    end

    // RAM address/data come only from latched values so they never follow idle port inputs.
    assign ram_addr  = addr_reg;
    assign ram_wdata = wdata_reg;
    assign ram_wren  = (state_reg == ACCESS) && we_reg;
    assign gnt0      = gnt_vec[0];
    assign gnt1      = gnt_vec[1];
    assign rvalid0   = rvalid_reg[0];
    assign rvalid1   = rvalid_reg[1];
    assign rdata     = rdata_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized scoreboard bench for ram_arbiter with a behavioural RAM and shadow memory.
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, rvalid0, gnt1, rvalid1;
    logic [7:0] rdata, ram_addr, ram_wdata, ram_q;
    logic       ram_wren, busy;

    always #5 clk = ~clk;

    ram_arbiter #(.WORD_SIZE(8), .ADDR_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .ram_q(ram_q), .busy(busy)
    );

    typedef struct { logic we; logic [7:0] addr; logic [7:0] data; } txn_t;
    typedef struct { int port; logic [7:0] data; int due; } rd_t;

    txn_t exp_q0[$], exp_q1[$];
    rd_t  rd_q[$];
    int   gnt_log[$], gnt_cyc[$];
    int   checks = 0, errors = 0, cycle = 0;
    int   last_win = 1;
    logic prev_req0 = 1'b0, prev_req1 = 1'b0, mon_en = 1'b0;
    logic [7:0] last_addr = 8'h00;
    bit   [7:0] shadow [256];
    bit         written [256];
    logic [7:0] mem [256];
    rd_t  rd_cur;

    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a == 8'h20) ? 8'h3C : (a ^ 8'h5A);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endfunction

    // Synchronous single-port RAM: address registered at the edge, q valid the following cycle.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_val(8'(i));
        ram_q = 8'h00;
        forever begin
            @(posedge clk);
            ram_q <= mem[ram_addr];
            if (ram_wren) mem[ram_addr] = ram_wdata;
        end
    end

    function automatic void grant(input int p);
        txn_t t;
        logic [7:0] e;
        chk("busy_in_access", 32'(busy), 32'd1);
        chk("grant_had_req", 32'((p == 0) ? prev_req0 : prev_req1), 32'd1);
        if (prev_req0 && prev_req1) chk("round_robin", 32'(p), 32'(1 - last_win));
        last_win = p;
        gnt_log.push_back(p);
        gnt_cyc.push_back(cycle);
        if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: got gnt%0d expected no grant (cycle %0d)", p, cycle);
            return;
        end
        if (p == 0) t = exp_q0.pop_front();
        else        t = exp_q1.pop_front();
        last_addr = t.addr;
        chk("ram_wren", 32'(ram_wren), 32'(t.we));
        chk("ram_addr", 32'(ram_addr), 32'(t.addr));
        if (t.we) begin
            chk("ram_wdata", 32'(ram_wdata), 32'(t.data));
            shadow[t.addr]  = t.data;
            written[t.addr] = 1'b1;
        end else begin
            e = written[t.addr] ? shadow[t.addr] : init_val(t.addr);
            rd_q.push_back('{p, e, cycle + 2});
        end
    endfunction

    // Monitor: samples mid-cycle, pops expectations whenever the DUT presents gnt/rvalid.
    always @(negedge clk) begin
        cycle++;
        if (mon_en) begin
            chk("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            chk("rvalid_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
            chk("wren_only_in_access", 32'(ram_wren & ~(gnt0 | gnt1)), 32'd0);
            if (!busy) chk("ram_addr_hold", 32'(ram_addr), 32'(last_addr));
            if (gnt0 ^ gnt1) grant(gnt1 ? 1 : 0);
            if (rvalid0 | rvalid1) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rvalid: got rvalid0=%0b rvalid1=%0b expected none (cycle %0d)",
                             rvalid0, rvalid1, cycle);
                end else begin
                    rd_cur = rd_q.pop_front();
                    chk("rvalid_port", 32'(rvalid1 ? 1 : 0), 32'(rd_cur.port));
                    chk("rdata", 32'(rdata), 32'(rd_cur.data));
                    chk("rvalid_latency", 32'(cycle), 32'(rd_cur.due));
                    chk("busy_idle_at_rvalid", 32'(busy), 32'd0);
                end
            end else if (rd_q.size() > 0 && rd_q[0].due <= cycle) begin
                checks++; errors++;
                $display("FAIL missing_rvalid: got none expected rvalid%0d (cycle %0d)", rd_q[0].port, cycle);
                void'(rd_q.pop_front());
            end
        end
        prev_req0 = req0;
        prev_req1 = req1;
        if (rst) begin
            last_win  = 1;
            last_addr = 8'h00;
        end
    end

    // Called at posedge+1; holds the request until granted, then releases after the next edge.
    task automatic issue(input int p, input logic we, input logic [7:0] a, input logic [7:0] d);
        txn_t t;
        int n;
        t = '{we, a, d};
        if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; exp_q0.push_back(t); end
        else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; exp_q1.push_back(t); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((p == 0) ? gnt0 : gnt1) == 1'b0 && n < 64);
        if (n >= 64) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got no gnt%0d expected grant within 64 cycles", p);
        end
        @(posedge clk); #1;
        if (p == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    int exp_order [4] = '{0, 1, 0, 1};

    initial begin
        rst = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
        req0 = 1'b1; req1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt0", 32'(gnt0), 0);       chk("reset_gnt1", 32'(gnt1), 0);
        chk("reset_rvalid0", 32'(rvalid0), 0); chk("reset_rvalid1", 32'(rvalid1), 0);
        chk("reset_wren", 32'(ram_wren), 0);   chk("reset_ram_addr", 32'(ram_addr), 0);
        chk("reset_ram_wdata", 32'(ram_wdata), 0);
        chk("reset_rdata", 32'(rdata), 0);     chk("reset_busy", 32'(busy), 0);
        realign();
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b0; mon_en = 1'b1;

        // Both ports held: grants alternate starting with port 0.
        gnt_log.delete();
        fork
            begin for (int i = 0; i < 2; i++) issue(0, 1'b1, 8'h40 + 8'(i), 8'h11 + 8'(i)); end
            begin for (int i = 0; i < 2; i++) issue(1, 1'b1, 8'h50 + 8'(i), 8'h22 + 8'(i)); end
        join
        #1;
        chk("alternate_count", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) chk("alternate_order", 32'(gnt_log[i]), 32'(exp_order[i]));

        // Write then read back through port 0.
        issue(0, 1'b1, 8'h10, 8'hA5);
        issue(0, 1'b0, 8'h10, 8'h00);
        @(negedge clk); @(negedge clk);
        chk("wr_rd_rvalid0", 32'(rvalid0), 32'd1);
        chk("wr_rd_rdata", 32'(rdata), 32'hA5);
        realign();

        // Back-to-back writes at the address extremes.
        gnt_cyc.delete();
        issue(0, 1'b1, 8'hFF, 8'h3E);
        issue(0, 1'b1, 8'h00, 8'hC1);
        #1;
        chk("b2b_grants", 32'(gnt_cyc.size()), 32'd2);
        if (gnt_cyc.size() == 2) chk("b2b_spacing", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd2);

        // Port 1 read of preloaded location.
        issue(1, 1'b0, 8'h20, 8'h00);
        @(negedge clk); @(negedge clk);
        chk("p1_rvalid1", 32'(rvalid1), 32'd1);
        chk("p1_rvalid0_quiet", 32'(rvalid0), 32'd0);
        chk("p1_rdata", 32'(rdata), 32'h3C);
        realign();

        // Port 1 arrives while a port 0 read is in flight.
        gnt_log.delete(); gnt_cyc.delete();
        fork
            begin issue(0, 1'b0, 8'h10, 8'h00); end
            begin @(negedge clk); @(posedge clk); #1; issue(1, 1'b1, 8'h60, 8'h77); end
        join
        #1;
        chk("inflight_grants", 32'(gnt_log.size()), 32'd2);
        if (gnt_cyc.size() == 2) chk("inflight_spacing", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd3);

        // Reset during RDWAIT aborts the read.
        realign();
        issue(0, 1'b0, 8'h10, 8'h00);
        rst = 1'b1;
        rd_q.delete();
        realign();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_rvalid0", 32'(rvalid0), 32'd0);
        realign();
        issue(0, 1'b0, 8'h10, 8'h00);
        @(negedge clk); @(negedge clk);
        chk("after_abort_rvalid0", 32'(rvalid0), 32'd1);
        chk("after_abort_rdata", 32'(rdata), 32'hA5);
        realign();

        // Random contention from both ports.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) realign();
                    issue(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) realign();
                    issue(1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
                end
            end
        join

        for (int i = 0; i < 20 && rd_q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_reads", 32'(rd_q.size()), 32'd0);
        chk("drain_port0", 32'(exp_q0.size()), 32'd0);
        chk("drain_port1", 32'(exp_q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 8, data width of RAM words and requester data.
REQ-002 Parameter ADDR_SIZE, default 8, RAM address width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  port 0 (CPU controller) access request; held with we0/addr0/wdata0 stable until gnt0.
REQ-006 we0  input  1  port 0 write (1) / read (0).
REQ-007 addr0  input  ADDR_SIZE  port 0 address.
REQ-008 wdata0  input  WORD_SIZE  port 0 write data.
REQ-009 gnt0  output  1  port 0 grant, one-cycle pulse.
REQ-010 rvalid0  output  1  port 0 read data valid, one-cycle pulse.
REQ-011 req1, we1, addr1, wdata1, gnt1, rvalid1: port 1 (I/O loader), same widths and meaning as port 0.
REQ-012 rdata  output  WORD_SIZE  registered read data, shared by both ports, qualified by rvalid0/rvalid1.
REQ-013 ram_addr  output  ADDR_SIZE  address to single-port RAM (RAM registers address; q one cycle later).
REQ-014 ram_wdata  output  WORD_SIZE  write data to RAM.
REQ-015 ram_wren  output  1  RAM write enable.
REQ-016 ram_q  input  WORD_SIZE  RAM read data.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, ACCESS, RDWAIT; exactly one access in flight.
REQ-019 IDLE, rising edge, any req high: latch winner's we/addr/wdata and owner id, set last_owner=winner, go ACCESS; no req: stay IDLE.
REQ-020 Arbitration round-robin: one req high -> that port wins; both high -> port other than last_owner wins.
REQ-021 ACCESS (exactly 1 cycle): ram_addr/ram_wdata driven from latched values; ram_wren = latched we; gnt of owner high, other gnt low.
REQ-022 ACCESS -> IDLE if latched we=1; ACCESS -> RDWAIT if latched we=0.
REQ-023 RDWAIT (exactly 1 cycle): ram_wren=0, ram_addr holds latched address; at ending edge rdata<=ram_q, owner's rvalid<=1, go IDLE.
REQ-024 rvalid high exactly one cycle (first IDLE cycle after RDWAIT); rdata holds value until next read completes.
REQ-025 Latency, req high before edge E0 in IDLE: gnt high E0-E1; write committed at E1; read rvalid high E2-E3 with data of addr at E1.
REQ-026 Throughput: write occupies 2 cycles (ACCESS+IDLE), read 3 cycles; new arbitration allowed in the cycle rvalid is high.
REQ-027 Requester drops req (or presents next access) by the edge after gnt; a req still high at the next IDLE sample is a new access.
REQ-028 ram_wren never high outside ACCESS; gnt0 and gnt1 never high together; rvalid0 and rvalid1 never high together.
REQ-029 ram_addr/ram_wdata in IDLE hold last latched values (no glitching to unselected port inputs).
REQ-030 Inputs of the losing port ignored while not granted; its request persists and wins the next IDLE sample if still high.
REQ-031 Address and data pass through unmodified; no address wrap or width conversion.

Reset
REQ-032 rst high at an edge: state=IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, ram_wren=0, ram_addr=0, ram_wdata=0, rdata=0, last_owner=1 (port 0 wins first tie), busy=0.
REQ-033 Reset mid-operation aborts the access: a write whose ACCESS cycle ends at the reset edge is committed by the RAM; a read in RDWAIT produces no rvalid.
REQ-034 rst overrides any simultaneous req; first arbitration is at the first edge with rst low.

Verification
REQ-035 Port 0 write addr 0x10 data 0xA5, then port 0 read 0x10 -> ram_wren high 1 cycle with ram_addr 0x10/ram_wdata 0xA5; rvalid0 pulse 2 cycles after gnt0, rdata=0xA5.
REQ-036 req0 and req1 both high after reset, held -> grants alternate 0,1,0,1; no overlapping gnt.
REQ-037 Port 1 read 0x20 (RAM holds 0x3C) while port 0 idle -> gnt1 then rvalid1 with rdata=0x3C; rvalid0 stays 0.
REQ-038 rst asserted during RDWAIT of port 0 read -> no rvalid0, next cycle busy=0, rdata=0; subsequent read completes normally.
REQ-039 req1 raised during port 0 read in flight -> req1 granted at first IDLE edge (same cycle as rvalid0), rdata from port 0 intact in that cycle.
REQ-040 Back-to-back writes port 0 to 0xFF, 0x00 -> each ram_wren pulse 1 cycle, 2-cycle spacing, addresses unaltered.
